// File: rtl/cipher_pkg.sv
// Shared types and the PRESENT S-box used by the byte-serial Feistel engine.
package cipher_pkg;

   localparam int KEY_W = 32;
   localparam int NIB   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   function automatic logic [3:0] f_round(input logic [3:0] r, input logic [3:0] k);
      return SBOX[r ^ k];
   endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational 4-bit Feistel round: (L,R) -> (R, L ^ F(R,k)).
module feistel_round
   import cipher_pkg::*;
(
   input  logic [3:0] i_l,
   input  logic [3:0] i_r,
   input  logic [3:0] i_k,
   output logic [3:0] o_l,
   output logic [3:0] o_r
);

   assign o_l = i_r;
   assign o_r = i_l ^ f_round(i_r, i_k);

endmodule

// File: rtl/feistel_byte_engine.sv
// Byte-serial Feistel cipher: one round per clock, 32-bit key shifted in bytewise.
//
//   state | meaning
//   IDLE  | waiting for an input byte; key_load accepted here only
//   RUN   | iterating rounds, r_rnd counts 0..NROUNDS-1
//   HOLD  | result presented on o_out_data until o_out_ready
module feistel_byte_engine
   import cipher_pkg::*;
#(
   parameter int NROUNDS = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_key_load,
   input  logic [7:0] i_key_byte,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  logic [7:0] i_in_data,
   input  logic       i_in_decrypt,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic [7:0] o_out_data,
   output logic       o_busy
);

   localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);
   localparam logic [2:0] LAST_K   = 3'((NROUNDS - 1) % 8);

   state_t           r_state;
   logic [KEY_W-1:0] r_key;
   logic [3:0]       r_l;
   logic [3:0]       r_r;
   logic [3:0]       r_rnd;
   logic             r_dec;
   logic [7:0]       r_out_data;
   logic             r_out_valid;

   logic [2:0]       w_ksel;
   logic [3:0]       w_k;
   logic [3:0]       w_l_nxt;
   logic [3:0]       w_r_nxt;

   // Decryption walks the round keys backwards; indices wrap mod 8.
   assign w_ksel = r_dec ? (LAST_K - r_rnd[2:0]) : r_rnd[2:0];
   assign w_k    = r_key[{w_ksel, 2'b00} +: NIB];

   feistel_round u_round (
      .i_l (r_l),
      .i_r (r_r),
      .i_k (w_k),
      .o_l (w_l_nxt),
      .o_r (w_r_nxt)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_key       <= '0;
         r_l         <= '0;
         r_r         <= '0;
         r_rnd       <= '0;
         r_dec       <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_key_load) begin
                  r_key <= {i_key_byte, r_key[KEY_W-1:8]};
               end
               if (i_in_valid) begin
                  r_l     <= i_in_data[7:4];
                  r_r     <= i_in_data[3:0];
                  r_dec   <= i_in_decrypt;
                  r_rnd   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_l   <= w_l_nxt;
               r_r   <= w_r_nxt;
               r_rnd <= r_rnd + 4'd1;
               if (r_rnd == LAST_RND) begin
                  r_out_data  <= {w_r_nxt, w_l_nxt};
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready  = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_feistel_byte_engine.sv
// Directed bench: index 0 drives an NROUNDS=2 engine, index 1 an NROUNDS=8 engine.
module tb_feistel_byte_engine;

   logic       clk = 1'b0;
   logic       rst       [2];
   logic       key_load  [2];
   logic [7:0] key_byte  [2];
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [7:0] in_data   [2];
   logic       in_dec    [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [7:0] out_data  [2];
   logic       busy      [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   feistel_byte_engine #(.NROUNDS(2)) u_nr2 (
      .i_clk(clk), .i_rst(rst[0]), .i_key_load(key_load[0]), .i_key_byte(key_byte[0]),
      .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]), .i_in_data(in_data[0]),
      .i_in_decrypt(in_dec[0]), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
      .o_out_data(out_data[0]), .o_busy(busy[0])
   );

   feistel_byte_engine #(.NROUNDS(8)) u_nr8 (
      .i_clk(clk), .i_rst(rst[1]), .i_key_load(key_load[1]), .i_key_byte(key_byte[1]),
      .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]), .i_in_data(in_data[1]),
      .i_in_decrypt(in_dec[1]), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
      .o_out_data(out_data[1]), .o_busy(busy[1])
   );

   // One byte through engine d; lat is the edge count from accept to out_valid, -1 on timeout.
   task automatic do_byte(input int d, input logic [7:0] x, input logic dec,
                          output logic [7:0] res, output int lat);
      int n;
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = x;
      in_dec[d]   = dec;
      @(negedge clk);
      in_valid[d] = 1'b0;
      n = 0;
      while (out_valid[d] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = (out_valid[d] === 1'b1) ? n : -1;
      res = out_data[d];
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
   endtask

   task automatic load_key(input int d, input logic [31:0] k);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         key_load[d] = 1'b1;
         key_byte[d] = k[8*i +: 8];
      end
      @(negedge clk);
      key_load[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; key_load[d] = 1'b0; key_byte[d] = 8'h00; in_valid[d] = 1'b0;
         in_data[d] = 8'h00; in_dec[d] = 1'b0; out_ready[d] = 1'b0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (out_valid[d] !== 1'b0 || out_data[d] !== 8'h00 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL reset_state dut%0d got v=%b d=%h busy=%b rdy=%b exp v=0 d=00 busy=0 rdy=1",
                     d, out_valid[d], out_data[d], busy[d], in_ready[d]);
         end
      end
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
   endtask

   task automatic test_nr2_zero_key();
      logic [7:0] res;
      int lat;
      do_byte(0, 8'h00, 1'b0, res, lat);
      checks++;
      if (res !== 8'h4C) begin failures++; $display("FAIL nr2_k0_enc got=%h exp=4c", res); end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL nr2_latency got=%0d exp=2", lat); end
      do_byte(0, 8'h4C, 1'b1, res, lat);
      checks++;
      if (res !== 8'h00) begin failures++; $display("FAIL nr2_k0_dec got=%h exp=00", res); end
   endtask

   task automatic test_nr2_key1();
      logic [7:0] res;
      int lat;
      load_key(0, 32'h0000_0001);
      do_byte(0, 8'h00, 1'b0, res, lat);
      checks++;
      if (res !== 8'h05) begin failures++; $display("FAIL nr2_k1_enc got=%h exp=05", res); end
      do_byte(0, 8'h05, 1'b1, res, lat);
      checks++;
      if (res !== 8'h00) begin failures++; $display("FAIL nr2_k1_dec got=%h exp=00", res); end
   endtask

   task automatic test_backpressure();
      logic [7:0] res;
      int lat;
      int n;
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 8'h00; in_dec[0] = 1'b0;
      @(negedge clk);
      in_data[0] = 8'hFF; key_load[0] = 1'b1; key_byte[0] = 8'hFF;
      n = 0;
      while (out_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h05 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_cycle%0d got v=%b d=%h rdy=%b busy=%b exp v=1 d=05 rdy=0 busy=1",
                     i, out_valid[0], out_data[0], in_ready[0], busy[0]);
         end
         @(negedge clk);
      end
      in_valid[0] = 1'b0; key_load[0] = 1'b0; out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== 8'h05) begin
         failures++;
         $display("FAIL hold_release got v=%b rdy=%b d=%h exp v=0 rdy=1 d=05",
                  out_valid[0], in_ready[0], out_data[0]);
      end
      // Key must still be 0x00000001: a leaked load of 0xFF would give 0x4C here.
      do_byte(0, 8'h00, 1'b0, res, lat);
      checks++;
      if (res !== 8'h05) begin failures++; $display("FAIL hold_key_kept got=%h exp=05", res); end
   endtask

   task automatic test_same_cycle_key();
      logic [7:0] res;
      int n;
      // Key 0x00000001 shifted by 0xAA becomes 0xAA000000 -> round keys 0,0 -> 0x4C.
      @(negedge clk);
      key_load[0] = 1'b1; key_byte[0] = 8'hAA;
      in_valid[0] = 1'b1; in_data[0] = 8'h00; in_dec[0] = 1'b0;
      @(negedge clk);
      key_load[0] = 1'b0; in_valid[0] = 1'b0;
      n = 0;
      while (out_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      res = out_data[0];
      checks++;
      if (out_valid[0] !== 1'b1 || res !== 8'h4C) begin
         failures++;
         $display("FAIL same_cycle_key got v=%b d=%h exp v=1 d=4c", out_valid[0], res);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
   endtask

   task automatic test_roundtrip_256();
      logic [7:0] ct [256];
      bit         seen [256];
      logic [7:0] res;
      int lat;
      load_key(1, $urandom());
      for (int x = 0; x < 256; x++) seen[x] = 1'b0;
      for (int x = 0; x < 256; x++) begin
         do_byte(1, 8'(x), 1'b0, ct[x], lat);
         checks++;
         if (lat !== 8 || seen[ct[x]]) begin
            failures++;
            $display("FAIL nr8_enc_%0d got lat=%0d dup=%b exp lat=8 dup=0", x, lat, seen[ct[x]]);
         end
         seen[ct[x]] = 1'b1;
      end
      for (int x = 0; x < 256; x++) begin
         do_byte(1, ct[x], 1'b1, res, lat);
         checks++;
         if (res !== 8'(x)) begin
            failures++;
            $display("FAIL nr8_roundtrip_%0d got=%h exp=%h", x, res, 8'(x));
         end
      end
   endtask

   task automatic test_rst_mid_run();
      logic [7:0] res;
      int lat;
      @(negedge clk);
      in_valid[1] = 1'b1; in_data[1] = 8'h5A; in_dec[1] = 1'b0;
      @(negedge clk);
      in_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst[1] = 1'b1;
      #1;
      checks++;
      if (out_valid[1] !== 1'b0 || out_data[1] !== 8'h00 || busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_run got v=%b d=%h busy=%b rdy=%b exp v=0 d=00 busy=0 rdy=1",
                  out_valid[1], out_data[1], busy[1], in_ready[1]);
      end
      @(negedge clk);
      rst[1] = 1'b0;
      // With the key cleared, 8 rounds over 0x00 give 0xC0.
      do_byte(1, 8'h00, 1'b0, res, lat);
      checks++;
      if (res !== 8'hC0) begin failures++; $display("FAIL rst_key_cleared_enc got=%h exp=c0", res); end
      do_byte(1, 8'hC0, 1'b1, res, lat);
      checks++;
      if (res !== 8'h00) begin failures++; $display("FAIL rst_key_cleared_dec got=%h exp=00", res); end
   endtask

   initial begin
      test_reset();
      test_nr2_zero_key();
      test_nr2_key1();
      test_backpressure();
      test_same_cycle_key();
      test_roundtrip_256();
      test_rst_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/feistel_byte_engine.md
Name: feistel_byte_engine

Overview:
Byte-serial cipher core that sits directly under the tt_um_Sai222777 top wrapper. The wrapper maps ui_in/uio_in/uo_out pins onto this block's ports. Each byte is encrypted or decrypted with an iterative 8-bit Feistel network, one round per clock. The 32-bit key is loaded one byte at a time, and both the byte input and the byte output use valid/ready handshakes.

Parameters:
NROUNDS, 8, number of Feistel rounds per byte; legal range 1..16.
KEY_W, 32, key register width; fixed at 32, giving 8 round-key nibbles.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
key_load  input  1  strobe: shift key_byte into the key register
key_byte  input  8  key byte
in_valid  input  1  input byte offered
in_ready  output  1  engine can accept a byte; equals (state==IDLE)
in_data  input  8  plaintext or ciphertext byte
in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with in_data
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  8  result byte
busy  output  1  high in RUN or HOLD

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, key=0, L=R=0, round counter=0, out_data=0, out_valid=0, busy=0, in_ready=1.
- Key register:
  - On key_load in IDLE: key <= {key_byte, key[31:8]}, so the first of four bytes ends in key[7:0].
  - key_load in RUN or HOLD is ignored.
  - If key_load and an accepted in_valid occur in the same IDLE cycle, both take effect; the captured byte is processed with the updated key.
- Round keys: k_i = key[4*(i mod 8) +: 4].
- Round function: F(r,k) = SBOX[r ^ k], using the PRESENT S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: L <= in_data[7:4], R <= in_data[3:0], latch in_decrypt, rnd <= 0, go to RUN.
- RUN:
  - Each cycle: (L,R) <= (R, L ^ F(R, key_sel)).
  - key_sel = k_rnd when encrypting, k_(NROUNDS-1-rnd) when decrypting.
  - rnd increments each cycle.
  - After the round with rnd==NROUNDS-1: out_data <= {new R, new L} (final swap), out_valid <= 1, go to HOLD.
- HOLD:
  - out_valid=1 and out_data held stable.
  - When out_ready=1: out_valid <= 0, go to IDLE. out_data keeps its last value.
- Latency: handshake at edge E gives out_valid high after edge E+NROUNDS. Throughput is one byte per NROUNDS+2 cycles when out_ready is tied high.
- Decrypt(Encrypt(x)) == x for every key and every NROUNDS.
- in_valid outside IDLE is not accepted; the upstream must hold it.
- rst asserted mid-RUN or mid-HOLD aborts the byte and clears the key; no partial output is emitted.
- Round counter width is 4 bits; it never wraps because the counter resets on each new byte.

Decomposition:
- Package cipher_pkg holds:
  - the SBOX constant array (16 x 4-bit)
  - state_t enum {IDLE, RUN, HOLD}
  - localparams KEY_W=32 and NIB=4
  - a function f_round(r,k)
- Sub-module feistel_round: purely combinational; inputs L, R, k; outputs next L and next R. One instance, reused every cycle.

Test Plan:
- NROUNDS=2, key=0x00000000, encrypt 0x00 -> out_valid rises 2 cycles after accept, out_data=0x4C; decrypt 0x4C -> 0x00.
- NROUNDS=2, load key bytes 0x01,0x00,0x00,0x00 -> key=0x00000001; encrypt 0x00 -> 0x05; decrypt 0x05 -> 0x00.
- NROUNDS=8, random 32-bit key, all 256 bytes encrypted then decrypted -> every byte round-trips exactly; ciphertexts are a permutation, with no duplicates.
- Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, in_valid and key_load ignored; then out_ready=1 -> out_valid falls next edge and in_ready=1.
- Assert rst for 1 cycle during RUN round 3 (NROUNDS=8) -> out_valid=0, out_data=0, key=0 immediately; the next encrypt of 0x00 with key=0 matches the golden model.
- Same-cycle key_load=1 (0xAA) with an accepted in_valid -> result matches a model that applies the shifted key to that byte.
